ddc112_conv_sequencer: RTL and testbench
========================================

Name: ddc112_conv_sequencer

Overview:
- Schedules DDC112 integration and readout.
- Toggles CONV once per integration period, detects the chip's DVALID_BAR data-ready strobe, and issues one readout request per conversion to the serial shifter/FIFO writer.
- Tracks overruns, dropped frames and missed conversions.
- Sits between the okWireIn configuration endpoints (enable, TINT) and the DDC112 shift/FIFO datapath in the okClk domain.

Parameters:
- TINT_MIN, 32'd5000: minimum integration period in okClk cycles; smaller TINT values are clamped up to this.
- FRAME_W, 16: width of the frame counter and drop counter.

Ports:
- okClk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run request (level), from wire-in
- TINT  in  32  integration period in okClk cycles
- dvalid_bar  in  1  DDC112 DVALID_BAR, asynchronous to okClk
- fifo_full  in  1  downstream FIFO cannot take a frame
- rd_done  in  1  1-cycle pulse from the shifter: frame readout finished
- CONV  out  1  DDC112 CONV
- rd_start  out  1  1-cycle pulse: shifter must assert DXMIT_BAR and read out the frame
- running  out  1  integration active
- frame_cnt  out  FRAME_W  frames read out since start
- drop_cnt  out  FRAME_W  frames skipped (FIFO full or overrun)
- overrun  out  1  sticky: DVALID seen while a readout was still busy
- missed  out  1  sticky: a period ended with no DVALID from the previous conversion
- frame_tag  out  FRAME_W  tag of the frame being read (see Optional Feature)

Behaviour:
- Reset (reset_n=0, any time, asynchronous): CONV=0, rd_start=0, running=0, frame_cnt=0, drop_cnt=0, overrun=0, missed=0, frame_tag=0. Both FSMs go to their idle state.
- dvalid_bar passes through a 2-flop synchronizer. An event is a falling edge of the synchronized signal, 1-cycle pulse dv_evt. Latency from pin to dv_evt is 3 cycles.
- TINT_eff = max(TINT, TINT_MIN). It is latched at every period start; TINT changes mid-period take effect in the next period.
- Integration FSM, states IDLE, RUN, STOPPING:
  - IDLE: CONV holds its level.
  - IDLE to RUN on enable=1. Load the period counter with TINT_eff-1, running=1, clear overrun, missed, frame_cnt and drop_cnt. Arm the discard_first flag.
  - RUN: count down each cycle. At 0, toggle CONV, reload TINT_eff-1, and run the missed check.
  - RUN to STOPPING when enable=0. The current period completes with its CONV toggle, then the FSM goes to IDLE with running=0. Re-asserting enable while in STOPPING does not abort the stop; the FSM re-enters RUN from IDLE on the next cycle.
  - Missed check: at each toggle after the first, if no dv_evt was seen since the previous toggle, set missed (sticky). Clear the dv_seen flag at every toggle.
- Readout FSM, states R_IDLE, R_BUSY:
  - R_IDLE, dv_evt, running or STOPPING:
    - If discard_first is set: clear it and take no readout. The first conversion after start is partial.
    - Else if fifo_full=1: increment drop_cnt, stay in R_IDLE.
    - Else: rd_start=1 for exactly one cycle on the cycle after dv_evt, latch frame_tag, go to R_BUSY.
  - R_BUSY, rd_done: increment frame_cnt, go to R_IDLE. The next dv_evt can be accepted in the following cycle.
  - R_BUSY, dv_evt: set overrun (sticky), increment drop_cnt, stay in R_BUSY.
  - rd_done and dv_evt in the same cycle while R_BUSY: complete the current frame and treat dv_evt as arriving in R_IDLE on the next cycle (single-entry pending latch). No drop.
  - dv_evt in IDLE (not running): ignored.
- Counters saturate at all-ones; they do not wrap.
- rd_start is never asserted while the readout FSM is in R_BUSY.

Optional Feature:
- Macro: DDC_FRAME_TAG_EN.
- Defined: a free-running period counter increments on every CONV toggle and is zeroed at start. frame_tag latches this counter at rd_start and holds until the next rd_start, which lets software detect gaps in the frame sequence.
- Not defined: frame_tag is tied to 0 and the period counter is not synthesized.

Test Plan:
1. reset_n=0 pulsed mid-RUN with CONV=1: all outputs return to their reset values asynchronously, without waiting for an okClk edge.
2. TINT=100, TINT_MIN=5000, enable=1: CONV toggles every 5000 cycles. With TINT=8000 written mid-period, the next period is 8000 cycles.
3. Enable; dvalid_bar pulses 200 cycles after each toggle; shifter returns rd_done 50 cycles after rd_start:
   - first dv_evt is discarded with no rd_start;
   - each later event gives rd_start 4 cycles after the pin edge;
   - after 10 toggles, frame_cnt=9.
4. A second dv_evt arrives while R_BUSY (rd_done delayed): overrun=1, drop_cnt=1, one rd_start only. A dv_evt in the same cycle as rd_done produces a second rd_start with no drop.
5. fifo_full=1 for 3 events: no rd_start, drop_cnt=3. No dvalid for one full period: missed=1 at the following toggle.
6. enable=0 mid-period: the period completes, one final CONV toggle, running=0, CONV level then held. With DDC_FRAME_TAG_EN defined, frame_tag values are consecutive except across drops.

Source files
------------

// File: rtl/ddc112_conv_sequencer.sv
// ddc112_conv_sequencer: DDC112 CONV period timer and DVALID-driven readout scheduler.
// Defining DDC_FRAME_TAG_EN tags each frame with the CONV period it was launched in.
module ddc112_conv_sequencer #(
  parameter logic [31:0] TINT_MIN = 32'd5000,
  parameter int          FRAME_W  = 16
) (
  input  logic               okClk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [31:0]        TINT,
  input  logic               dvalid_bar,
  input  logic               fifo_full,
  input  logic               rd_done,
  output logic               CONV,
  output logic               rd_start,
  output logic               running,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [FRAME_W-1:0] drop_cnt,
  output logic               overrun,
  output logic               missed,
  output logic [FRAME_W-1:0] frame_tag
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2;
  localparam logic R_IDLE = 1'b0, R_BUSY = 1'b1;
  logic [1:0]  state;
  logic        rd_state;
  logic [31:0] cnt, tint_eff;
  logic [2:0]  sync;
  logic        dv_evt, pend, dv_seen, toggled, discard_first;
  logic        tick, start, evt, launch;
  function automatic logic [FRAME_W-1:0] sat_inc(input logic [FRAME_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  assign tint_eff = (TINT < TINT_MIN) ? TINT_MIN : TINT;
  assign running  = state != S_IDLE;
  assign start    = state == S_IDLE && enable;
  assign tick     = running && cnt == 32'd0;
  assign evt      = running && (dv_evt || pend);
  assign launch   = rd_state == R_IDLE && evt && !discard_first && !fifo_full;
  // sync[1:0] is the metastability pair; sync[2] is the previous synchronized level
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= 3'b111;
      dv_evt <= 1'b0;
    end else begin
      sync   <= {sync[1:0], dvalid_bar};
      dv_evt <= sync[2] & ~sync[1];
    end
  end
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rd_state      <= R_IDLE;
      cnt           <= '0;
      CONV          <= 1'b0;
      rd_start      <= 1'b0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
      overrun       <= 1'b0;
      missed        <= 1'b0;
      pend          <= 1'b0;
      dv_seen       <= 1'b0;
      toggled       <= 1'b0;
      discard_first <= 1'b0;
    end else begin
      rd_start <= launch;
      pend     <= 1'b0;
      if (rd_state == R_IDLE) begin
        if (evt && discard_first) discard_first <= 1'b0;
        else if (evt && fifo_full) drop_cnt <= sat_inc(drop_cnt);
        else if (launch) rd_state <= R_BUSY;
      end else if (rd_done) begin
        frame_cnt <= sat_inc(frame_cnt);
        rd_state  <= R_IDLE;
        pend      <= dv_evt && running;
      end else if (dv_evt && running) begin
        overrun  <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
      // start is last so its clears win over the readout updates above
      if (start) begin
        state         <= S_RUN;
        cnt           <= tint_eff - 32'd1;
        overrun       <= 1'b0;
        missed        <= 1'b0;
        frame_cnt     <= '0;
        drop_cnt      <= '0;
        discard_first <= 1'b1;
        dv_seen       <= 1'b0;
        toggled       <= 1'b0;
        rd_state      <= R_IDLE;
        pend          <= 1'b0;
      end else if (tick) begin
        CONV    <= ~CONV;
        cnt     <= tint_eff - 32'd1;
        dv_seen <= 1'b0;
        toggled <= 1'b1;
        missed  <= missed | (toggled & ~dv_seen);
        state   <= (state == S_STOP || !enable) ? S_IDLE : S_RUN;
      end else if (running) begin
        cnt     <= cnt - 32'd1;
        dv_seen <= dv_seen | dv_evt;
        state   <= (enable && state == S_RUN) ? S_RUN : S_STOP;
      end
    end
  end
`ifdef DDC_FRAME_TAG_EN
  logic [FRAME_W-1:0] period_cnt;
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      frame_tag  <= '0;
    end else begin
      period_cnt <= start ? '0 : tick ? period_cnt + 1'b1 : period_cnt;
      if (launch) frame_tag <= period_cnt;
    end
  end
`else
  assign frame_tag = '0;
`endif
endmodule

// File: tb/tb_ddc112_conv_sequencer.sv
// tb_ddc112_conv_sequencer: period timing, readout scheduling, drops/overrun/missed and async reset.
module tb_ddc112_conv_sequencer;
  localparam logic [31:0] TMIN = 32'd400;
  localparam int FW = 16;
`ifdef DDC_FRAME_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  logic okClk = 1'b0;
  logic reset_n, enable, dvalid_bar, fifo_full, rd_done;
  logic auto_pulse, man_pulse;
  logic [31:0] TINT;
  logic CONV, rd_start, running, overrun, missed;
  logic [FW-1:0] frame_cnt, drop_cnt, frame_tag;
  int cyc = 0, n_cmp = 0, n_err = 0, tog = 0, t_prev = 0, rd_lat = 50;
  bit auto_done = 1'b1;
  typedef struct {int cyc; int tag;} rd_exp_t;
  typedef struct {bit dv; bit ff; bit rd; int frame; int drop; bit miss;} row_t;
  rd_exp_t sb[$];
  rd_exp_t e;
  row_t tbl[10];

  ddc112_conv_sequencer #(.TINT_MIN(TMIN), .FRAME_W(FW)) dut (
    .okClk(okClk), .reset_n(reset_n), .enable(enable), .TINT(TINT),
    .dvalid_bar(dvalid_bar), .fifo_full(fifo_full), .rd_done(rd_done),
    .CONV(CONV), .rd_start(rd_start), .running(running), .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt), .overrun(overrun), .missed(missed), .frame_tag(frame_tag)
  );

  assign rd_done = auto_pulse | man_pulse;
  always #5 okClk = ~okClk;
  always @(posedge okClk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_toggle();
    logic old;
    int n;
    old = CONV;
    n = 0;
    do begin
      @(negedge okClk);
      n++;
    end while (CONV == old && n < 3000);
    if (CONV == old) begin
      n_cmp++;
      n_err++;
      $display("FAIL conv_toggle_timeout: no CONV change within %0d cycles", n);
    end else tog++;
  endtask

  task automatic pulse_dv();
    dvalid_bar = 1'b0;
    repeat (3) @(negedge okClk);
    dvalid_bar = 1'b1;
  endtask

  task automatic push_rd(input int lat);
    sb.push_back('{cyc + lat, TAG_EN ? tog : 0});
  endtask

  always @(negedge okClk) begin
    if (reset_n && rd_start) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_start_unexpected: asserted at cycle %0d, none required", cyc);
      end else begin
        e = sb.pop_front();
        chk("rd_start_cycle", cyc, e.cyc);
        chk("frame_tag", frame_tag, e.tag);
      end
    end
  end

  initial begin
    auto_pulse = 1'b0;
    forever begin
      @(negedge okClk);
      if (rd_start && auto_done) begin
        repeat (rd_lat) @(negedge okClk);
        auto_pulse = 1'b1;
        @(negedge okClk);
        auto_pulse = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saved;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    for (int i = 1; i <= 4; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, i, 0, 1'b0};
    for (int i = 5; i <= 7; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 4, i - 4, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 4, 3, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 5, 3, 1'b1};
    reset_n = 1'b0; enable = 1'b0; TINT = 32'd100; dvalid_bar = 1'b1;
    fifo_full = 1'b0; man_pulse = 1'b0;
    repeat (3) @(negedge okClk);
    reset_n = 1'b1;
    @(negedge okClk);
    chk("rst_conv", CONV, 0);
    chk("rst_running", running, 0);
    chk("rst_rd_start", rd_start, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_missed", missed, 0);
    chk("rst_frame_tag", frame_tag, 0);
    // clamped period, mid-period TINT change, then stop
    enable = 1'b1;
    wait_toggle();
    t_prev = cyc;
    chk("t1_running", running, 1);
    chk("t1_missed", missed, 0);
    wait_toggle();
    chk("period_clamped", cyc - t_prev, TMIN);
    chk("missed_no_dvalid", missed, 1);
    t_prev = cyc;
    repeat (100) @(negedge okClk);
    TINT = 32'd800;
    wait_toggle();
    chk("period_before_change", cyc - t_prev, TMIN);
    t_prev = cyc;
    wait_toggle();
    chk("period_after_change", cyc - t_prev, 800);
    t_prev = cyc;
    repeat (300) @(negedge okClk);
    enable = 1'b0;
    @(negedge okClk);
    chk("stopping_running", running, 1);
    wait_toggle();
    chk("stop_period_completes", cyc - t_prev, 800);
    chk("stop_running", running, 0);
    saved = CONV;
    repeat (1000) @(negedge okClk);
    chk("idle_conv_held", CONV, saved);
    // table-driven readout periods
    TINT = 32'd0;
    tog = 0;
    enable = 1'b1;
    @(negedge okClk);
    chk("restart_running", running, 1);
    chk("restart_missed_clr", missed, 0);
    wait_toggle();
    for (int i = 0; i < 10; i++) begin
      fifo_full = tbl[i].ff;
      repeat (200) @(negedge okClk);
      if (tbl[i].dv) begin
        if (tbl[i].rd) push_rd(4);
        pulse_dv();
      end
      wait_toggle();
      chk($sformatf("row%0d_frame_cnt", i), frame_cnt, tbl[i].frame);
      chk($sformatf("row%0d_drop_cnt", i), drop_cnt, tbl[i].drop);
      chk($sformatf("row%0d_missed", i), missed, tbl[i].miss);
    end
    fifo_full = 1'b0;
    chk("pre_overrun", overrun, 0);
    // overrun while busy, then dv_evt coinciding with rd_done
    auto_done = 1'b0;
    repeat (20) @(negedge okClk);
    push_rd(4);
    pulse_dv();
    repeat (100) @(negedge okClk);
    pulse_dv();
    repeat (20) @(negedge okClk);
    chk("busy_overrun", overrun, 1);
    chk("busy_drop_cnt", drop_cnt, 4);
    chk("busy_frame_cnt", frame_cnt, 5);
    repeat (80) @(negedge okClk);
    push_rd(5);
    dvalid_bar = 1'b0;
    repeat (3) @(negedge okClk);
    man_pulse = 1'b1;
    dvalid_bar = 1'b1;
    @(negedge okClk);
    man_pulse = 1'b0;
    chk("coincide_frame_cnt", frame_cnt, 6);
    repeat (20) @(negedge okClk);
    man_pulse = 1'b1;
    @(negedge okClk);
    man_pulse = 1'b0;
    repeat (5) @(negedge okClk);
    chk("coincide_frame_cnt_done", frame_cnt, 7);
    chk("coincide_no_drop", drop_cnt, 4);
    chk("sb_drained", sb.size(), 0);
    auto_done = 1'b1;
    // asynchronous reset mid-run with CONV high
    if (CONV == 1'b0) wait_toggle();
    chk("pre_reset_conv", CONV, 1);
    @(posedge okClk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_conv", CONV, 0);
    chk("async_running", running, 0);
    chk("async_rd_start", rd_start, 0);
    chk("async_frame_cnt", frame_cnt, 0);
    chk("async_drop_cnt", drop_cnt, 0);
    chk("async_overrun", overrun, 0);
    chk("async_missed", missed, 0);
    chk("async_frame_tag", frame_tag, 0);
    enable = 1'b0;
    @(negedge okClk);
    reset_n = 1'b1;
    repeat (2) @(negedge okClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
